dmem_responder: RTL and testbench
=================================

# dmem_responder

Responder end of the processor's data-memory port: accepts `address_dmem`/`data`/`wren` from the pipeline and returns `q_dmem`. Word-addressed RAM is combined with a memory-mapped I/O page containing a transmit FIFO, a free-running cycle counter, and a compare timer. It is instantiated in Wrapper between the processor and the outside world, clocked by the memory clock Wrapper supplies.

## Interface
- `RAM_WORDS`, 4096: RAM size in words (word addresses 0 .. RAM_WORDS-1).
- `IO_BASE`, 32'h0000_1000: word address of the I/O page.
- `FIFO_DEPTH`, 8: transmit FIFO entries. Must be a power of 2, minimum 2.

Ports:
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `address_dmem` in 32: word address from processor.
- `data` in 32: write data.
- `wren` in 1: write strobe; a write takes effect at this edge.
- `q_dmem` out 32: registered read data.
- `tx_valid` out 1: FIFO non-empty.
- `tx_data` out 32: FIFO head word.
- `tx_ready` in 1: consumer pops the head when `tx_valid & tx_ready`.
- `timer_irq` out 1: timer expired flag.
- `bus_err` out 1: sticky; set by any access to an unmapped address.

## Operation
Every access is one cycle. There are no wait states and no handshake on the processor side.

Address map (word addresses):
- `< RAM_WORDS`: RAM read/write.
- `IO_BASE+0` TXDATA: write pushes `data` into the FIFO. Read returns 0.
- `IO_BASE+1` STATUS (read-only): bit0 full, bit1 empty, bit2 overflow (sticky), bits[15:8] count. Writing 1 to bit2 clears overflow.
- `IO_BASE+2` CYCLES: read returns the counter value. Write loads the counter with `data`.
- `IO_BASE+3` COMPARE: read/write.
- `IO_BASE+4` TSTAT: bit0 expired. Writing 1 to bit0 clears it.
- Any other address: reads return 0, writes are ignored, and `bus_err` sets (including on reads).

Rules:
- **Reads.** `q_dmem` is loaded at the edge with the addressed value as it stood before that edge (read-before-write). A same-address RAM write during a read returns the old word.
- **Write strobe.** With `wren`=0, no write side effects occur; reads still occur every cycle.
- **Cycle counter.**
  - Increments by 1 every cycle, wrapping from 0xFFFF_FFFF to 0.
  - A CYCLES write loads `data` instead of incrementing that cycle.
- **Timer.**
  - Expired sets at an edge when the pre-edge counter equals COMPARE.
  - If a set and a clear coincide, set wins.
  - `timer_irq` = expired.
- **FIFO push/pop.**
  - Pop occurs when `tx_valid & tx_ready`.
  - A push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - A push to a full FIFO without a pop is dropped and sets overflow.
  - A simultaneous push and pop with the FIFO empty: pop is ignored (`tx_valid` was 0) and the push is accepted.
- **FIFO read/write pointers** are log2(FIFO_DEPTH) bits and wrap naturally. Count is kept separately, 0..FIFO_DEPTH.
- **`tx_data` and flags.** `tx_data` is the head entry, or 0 when empty. full = (count == FIFO_DEPTH); empty = (count == 0).

## Timing
- **Reset values** (at the edge with `reset`=1, overriding any same-cycle access):
  - `q_dmem`=0, count=0, pointers=0, overflow=0.
  - CYCLES=0, COMPARE=0xFFFF_FFFF, expired=0.
  - `bus_err`=0, `tx_valid`=0, `tx_data`=0.
  - RAM contents are not reset.
- **Read latency.** Address presented before edge N; `q_dmem` is valid after edge N and holds until edge N+1. Wrapper drives `clock` so that this falls before the processor's MW latch edge.
- **Write visibility.** A write at edge N is visible to a read issued at edge N+1.
- **Counter read value.** A CYCLES read at edge N returns the pre-edge value. After reset deasserts at edge R, the first read at edge R+1 returns 0.
- **FIFO status.** `tx_valid` rises one edge after the first accepted push, with no combinational path from `wren`. A STATUS read returns the pre-edge count and flags.
- **Reset mid-operation.** Discards FIFO contents and any in-flight push; the same-cycle write is not performed.

## Test plan
- **RAM write/read.** Write 0xDEADBEEF to addr 5; read addr 5 the next cycle -> `q_dmem`=0xDEADBEEF. Read addr 5 in the same cycle as writing 0x1 -> returns 0xDEADBEEF, and the following read returns 0x1.
- **FIFO overflow.** Push 1..9 with `tx_ready`=0 -> STATUS = full=1, count=8, overflow=1. Then hold `tx_ready`=1 -> `tx_data` sequence 1..8, then `tx_valid`=0, empty=1.
- **Push/pop at full.** Fill the FIFO, then push 0xAA while popping -> count stays 8, overflow stays 0, 0xAA is the last word out.
- **Timer.** Reset, write COMPARE=20 -> `timer_irq` rises after the edge where the counter is 20. Write TSTAT=1 on the same edge as a new match -> flag remains 1.
- **Counter load and wrap.** Write CYCLES=0xFFFF_FFFE; reads on the next two cycles return 0xFFFF_FFFE, then 0xFFFF_FFFF. The read after that returns 0x0.
- **Unmapped access and reset.** Read addr IO_BASE+9 -> `q_dmem`=0, `bus_err`=1. Assert `reset` during a TXDATA push -> count=0, `bus_err`=0, `q_dmem`=0.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the processor pipeline.
// Word-addressed RAM plus an I/O page holding a transmit FIFO, a free-running
// cycle counter and a compare timer. Every access completes in one cycle and
// read data is registered (read-before-write).
module dmem_responder #(
  parameter int          RAM_WORDS  = 4096,
  parameter logic [31:0] IO_BASE    = 32'h0000_1000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic        tx_valid,
  output logic [31:0] tx_data,
  input  logic        tx_ready,
  output logic        timer_irq,
  output logic        bus_err
);

  localparam int RAW = $clog2(RAM_WORDS);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;

  // I/O page register offsets
  localparam logic [31:0] OFF_TXDATA  = 32'd0;
  localparam logic [31:0] OFF_STATUS  = 32'd1;
  localparam logic [31:0] OFF_CYCLES  = 32'd2;
  localparam logic [31:0] OFF_COMPARE = 32'd3;
  localparam logic [31:0] OFF_TSTAT   = 32'd4;
  localparam logic [31:0] IO_REGS     = 32'd5;

  // ---------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------
  logic [31:0]   ram [RAM_WORDS];
  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [31:0]   cycles;
  logic [31:0]   compare;
  logic          expired;
  logic          bus_err_q;

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic [31:0]  io_off;
  logic         in_ram, in_io;
  logic         sel_tx, sel_status, sel_cycles, sel_compare, sel_tstat;
  logic         unmapped;
  logic [RAW-1:0] ram_idx;

  // RAM wins over the I/O page should the two ever be configured to overlap.
  always_comb begin
    io_off      = address_dmem - IO_BASE;
    in_ram      = address_dmem < 32'(RAM_WORDS);
    in_io       = !in_ram && (address_dmem >= IO_BASE) && (io_off < IO_REGS);
    sel_tx      = in_io && (io_off == OFF_TXDATA);
    sel_status  = in_io && (io_off == OFF_STATUS);
    sel_cycles  = in_io && (io_off == OFF_CYCLES);
    sel_compare = in_io && (io_off == OFF_COMPARE);
    sel_tstat   = in_io && (io_off == OFF_TSTAT);
    unmapped    = !in_ram && !in_io;
    ram_idx     = address_dmem[RAW-1:0];
  end

  // ---------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------
  logic full, empty, pop, push_req, push_ok, push_drop;

  // Flags come only from registered state, so tx_valid has no path from wren.
  always_comb begin
    empty     = (count == '0);
    full      = (count == CW'(FIFO_DEPTH));
    pop       = !empty && tx_ready;
    push_req  = wren && sel_tx;
    push_ok   = push_req && (!full || pop);
    push_drop = push_req && full && !pop;
  end

  // Head word is masked to 0 while empty so stale entries never leak out.
  always_comb begin
    tx_valid = !empty;
    tx_data  = empty ? 32'd0 : fifo_mem[rd_ptr];
  end

  // ---------------------------------------------------------------------
  // Read mux: values as they stand before the edge
  // ---------------------------------------------------------------------
  logic [31:0] rd_val;

  // Select the addressed value; unmapped and TXDATA read as 0.
  always_comb begin
    rd_val = 32'd0;
    if (in_ram) begin
      rd_val = ram[ram_idx];
    end else if (sel_status) begin
      rd_val[0]    = full;
      rd_val[1]    = empty;
      rd_val[2]    = overflow;
      rd_val[15:8] = 8'(count);
    end else if (sel_cycles) begin
      rd_val = cycles;
    end else if (sel_compare) begin
      rd_val = compare;
    end else if (sel_tstat) begin
      rd_val[0] = expired;
    end
  end

  // ---------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------

  // RAM write port; contents survive reset, but a write coinciding with
  // reset is suppressed.
  always_ff @(posedge clock) begin
    if (!reset && wren && in_ram) ram[ram_idx] <= data;
  end

  // FIFO storage; an in-flight push is discarded by reset.
  always_ff @(posedge clock) begin
    if (!reset && push_ok) fifo_mem[wr_ptr] <= data;
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Drop and clear target different registers, so they never collide.
      if (push_drop)
        overflow <= 1'b1;
      else if (wren && sel_status && data[2])
        overflow <= 1'b0;
    end
  end

  // Cycle counter, compare register and expired flag (set beats clear).
  always_ff @(posedge clock) begin
    if (reset) begin
      cycles  <= 32'd0;
      compare <= 32'hFFFF_FFFF;
      expired <= 1'b0;
    end else begin
      cycles <= (wren && sel_cycles) ? data : cycles + 32'd1;
      if (wren && sel_compare) compare <= data;
      if (cycles == compare)
        expired <= 1'b1;
      else if (wren && sel_tstat && data[0])
        expired <= 1'b0;
    end
  end

  // Registered read data and sticky bus error (reads count as accesses).
  always_ff @(posedge clock) begin
    if (reset) begin
      q_dmem    <= 32'd0;
      bus_err_q <= 1'b0;
    end else begin
      q_dmem    <= rd_val;
      bus_err_q <= bus_err_q | unmapped;
    end
  end

  assign timer_irq = expired;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a queue-based reference model predicts
// every post-edge output; a monitor pops and compares one entry per cycle.
module tb_dmem_responder;

  localparam logic [31:0] IOB = 32'h0000_1000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address_dmem = 32'd0;
  logic [31:0] data = 32'd0;
  logic        wren = 1'b0;
  logic [31:0] q_dmem;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready = 1'b0;
  logic        timer_irq;
  logic        bus_err;

  always #5 clock = ~clock;

  dmem_responder #(.RAM_WORDS(4096), .IO_BASE(IOB), .FIFO_DEPTH(8)) dut (
    .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data),
    .wren(wren), .q_dmem(q_dmem), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .timer_irq(timer_irq), .bus_err(bus_err)
  );

  typedef struct {
    logic [31:0] q;
    bit          q_known;
    logic        tv;
    logic [31:0] td;
    logic        irq;
    logic        be;
  } exp_t;

  exp_t sb[$];

  // reference model state
  logic [31:0] m_ram [int];
  logic [31:0] m_fifo [$];
  bit          m_ovf;
  logic [31:0] m_cyc, m_cmp;
  bit          m_exp, m_berr;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // monitor: one expected entry per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.q_known) chk("q_dmem", q_dmem, e.q);
        chk("tx_valid", 32'(tx_valid), 32'(e.tv));
        chk("tx_data", tx_data, e.td);
        chk("timer_irq", 32'(timer_irq), 32'(e.irq));
        chk("bus_err", 32'(bus_err), 32'(e.be));
      end
    end
  end

  // drive one cycle and predict the outputs seen after its rising edge
  task automatic step(input logic r, input logic [31:0] a, input logic [31:0] d,
                      input logic w, input logic rdy);
    exp_t e;
    logic [31:0] rv;
    bit known;
    bit pop, push;
    int sz;
    @(negedge clock);
    reset = r; address_dmem = a; data = d; wren = w; tx_ready = rdy;
    rv = 32'd0;
    known = 1'b1;
    if (r) begin
      m_fifo.delete();
      m_ovf = 0; m_cyc = 32'd0; m_cmp = 32'hFFFF_FFFF; m_exp = 0; m_berr = 0;
    end else begin
      sz = m_fifo.size();
      if (a < 32'd4096) begin
        if (m_ram.exists(int'(a))) rv = m_ram[int'(a)];
        else known = 1'b0;
      end else if (a == IOB + 32'd1) begin
        rv = {16'h0, 8'(sz), 5'h0, m_ovf, (sz == 0), (sz == 8)};
      end else if (a == IOB + 32'd2) rv = m_cyc;
      else if (a == IOB + 32'd3) rv = m_cmp;
      else if (a == IOB + 32'd4) rv = {31'h0, m_exp};
      if (!(a < 32'd4096) && !(a >= IOB && a < IOB + 32'd5)) m_berr = 1;

      pop  = (sz > 0) && rdy;
      push = w && (a == IOB);
      if (pop) void'(m_fifo.pop_front());
      if (push) begin
        if (m_fifo.size() < 8) m_fifo.push_back(d);
        else m_ovf = 1;
      end
      if (w && a == IOB + 32'd1 && d[2]) m_ovf = 0;

      if (m_cyc == m_cmp) m_exp = 1;
      else if (w && a == IOB + 32'd4 && d[0]) m_exp = 0;
      if (w && a == IOB + 32'd3) m_cmp = d;
      m_cyc = (w && a == IOB + 32'd2) ? d : m_cyc + 32'd1;
      if (w && a < 32'd4096) m_ram[int'(a)] = d;
    end
    e.q       = rv;
    e.q_known = known;
    e.tv      = (m_fifo.size() > 0);
    e.td      = (m_fifo.size() > 0) ? m_fifo[0] : 32'd0;
    e.irq     = m_exp;
    e.be      = m_berr;
    sb.push_back(e);
  endtask

  initial begin
    logic [31:0] a, d;
    logic w, rdy, r;
    int pick;

    step(1, 32'd0, 32'd0, 0, 0);
    step(1, IOB + 32'd2, 32'h1234, 1, 1);

    // preload the RAM words the random phase reads
    for (int i = 0; i < 16; i++) step(0, 32'(i), $urandom, 1, 0);
    step(0, 32'd4095, $urandom, 1, 0);

    // RAM write/read and read-before-write
    step(0, 32'd5, 32'hDEAD_BEEF, 1, 0);
    step(0, 32'd5, 32'd0, 0, 0);
    step(0, 32'd5, 32'd1, 1, 0);
    step(0, 32'd5, 32'd0, 0, 0);

    // FIFO overflow then drain
    for (int i = 1; i <= 9; i++) step(0, IOB, 32'(i), 1, 0);
    step(0, IOB + 32'd1, 32'd0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, IOB + 32'd1, 32'd0, 0, 1);
    step(0, IOB + 32'd1, 32'd4, 1, 0);
    step(0, IOB + 32'd1, 32'd0, 0, 0);

    // push while popping at full
    for (int i = 0; i < 8; i++) step(0, IOB, 32'h100 + 32'(i), 1, 0);
    step(0, IOB, 32'hAA, 1, 1);
    step(0, IOB + 32'd1, 32'd0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, IOB + 32'd1, 32'd0, 0, 1);

    // timer: compare=20 after reset, then set-beats-clear
    step(1, IOB + 32'd1, 32'd0, 0, 0);
    step(0, IOB + 32'd3, 32'd20, 1, 0);
    for (int i = 0; i < 25; i++) step(0, IOB + 32'd4, 32'd0, 0, 0);
    step(0, IOB + 32'd2, 32'd100, 1, 0);
    step(0, IOB + 32'd3, 32'd102, 1, 0);
    step(0, IOB + 32'd4, 32'd1, 1, 0);
    step(0, IOB + 32'd4, 32'd1, 1, 0);
    step(0, IOB + 32'd4, 32'd0, 0, 0);

    // counter load and wrap
    step(0, IOB + 32'd2, 32'hFFFF_FFFE, 1, 0);
    for (int i = 0; i < 3; i++) step(0, IOB + 32'd2, 32'd0, 0, 0);

    // unmapped access, then reset during a push
    step(0, IOB + 32'd9, 32'd0, 0, 0);
    step(0, IOB, 32'h55, 1, 0);
    step(1, IOB, 32'h66, 1, 0);
    step(0, IOB + 32'd1, 32'd0, 0, 0);

    // randomized phase
    for (int k = 0; k < 3000; k++) begin
      pick = $urandom_range(0, 99);
      if (pick < 35) begin
        pick = $urandom_range(0, 16);
        a = (pick == 16) ? 32'd4095 : 32'(pick);
      end else if (pick < 60) a = IOB;
      else if (pick < 90) a = IOB + 32'($urandom_range(1, 4));
      else if (pick < 92) begin
        case ($urandom_range(0, 3))
          0: a = IOB + 32'd5;
          1: a = IOB + 32'd9;
          2: a = 32'h0000_2000;
          default: a = 32'hFFFF_FFFF;
        endcase
      end else a = IOB + 32'd1;
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      if (a == IOB + 32'd2 && $urandom_range(0, 1) == 1) d = m_cmp - 32'($urandom_range(0, 5));
      if (((k / 150) % 2) == 0) rdy = ($urandom_range(0, 9) == 0);
      else rdy = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 199) == 0);
      step(r, a, d, w, rdy);
    end

    repeat (3) @(negedge clock);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
